// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction classes produced by the decoder and
// consumed by the execution sequencer, plus the stage-enable payload.
package cpu_pkg;

    localparam int unsigned INST_W = 3;

    // Codes 0 and 7 are not assigned to any instruction and decode as illegal.
    typedef enum logic [INST_W-1:0] {
        IC_ILLEGAL = 3'd0,
        IC_ALU     = 3'd1,
        IC_JUMPI   = 3'd2,
        IC_JUMP    = 3'd3,
        IC_MOVE    = 3'd4,
        IC_STORE   = 3'd5,
        IC_LOAD    = 3'd6,
        IC_RSVD    = 3'd7
    } inst_class_t;

    // One-hot datapath stage enables (branch enable is handled separately).
    typedef struct packed {
        logic fetch;
        logic decode;
        logic reg_r;
        logic alu;
        logic reg_w;
        logic mem_r;
        logic mem_w;
    } stage_en_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Sequencer bundle: decoder/memory handshake inputs, stage enables and status.
//   master : drives start, inst_type, is_halt, mem_ready; observes the rest
//   slave  : the sequencer side (exec_sequencer)
interface exec_sequencer_if
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic                 start;
    logic [INST_W-1:0]    inst_type;
    logic                 is_halt;
    logic                 mem_ready;

    logic                 fetch_unit_en;
    logic                 decoder_en;
    logic                 reg_r_en;
    logic                 alu_en;
    logic                 reg_w_en;
    logic                 memory_r_en;
    logic                 memory_w_en;
    logic                 br_en;

    logic                 inst_retire;
    logic                 illegal;
    logic                 done;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     retire_cnt;

    modport master (
        output start, inst_type, is_halt, mem_ready,
        input  fetch_unit_en, decoder_en, reg_r_en, alu_en, reg_w_en,
               memory_r_en, memory_w_en, br_en,
               inst_retire, illegal, done, cycle_cnt, retire_cnt
    );

    modport slave (
        input  start, inst_type, is_halt, mem_ready,
        output fetch_unit_en, decoder_en, reg_r_en, alu_en, reg_w_en,
               memory_r_en, memory_w_en, br_en,
               inst_retire, illegal, done, cycle_cnt, retire_cnt
    );

endinterface

// File: rtl/perf_counter.sv
// Event counter that either wraps modulo 2^W or saturates at all-ones.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   count      : current count (registered)
module perf_counter #(
    parameter int unsigned W        = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic at_max;
    assign at_max = SATURATE && (count == MAX);

    // Increment; a saturating counter stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle CPU execution sequencer: walks each instruction through its
// datapath stages, raises one stage enable per cycle, and counts busy cycles
// and retired instructions.
//   clk    : clock
//   init_n : async active-low reset
//   bus    : exec_sequencer_if slave (handshake inputs, enables, status, counters)
// Stage enables and done are registered; br_en, illegal and inst_retire depend
// on the inputs sampled in the current state and are combinational.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            init_n,
    exec_sequencer_if.slave bus
);

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_IDLE    = 4'd0;
    localparam seq_state_t S_FETCH   = 4'd1;
    localparam seq_state_t S_DECODE  = 4'd2;
    localparam seq_state_t S_OPFETCH = 4'd3;
    localparam seq_state_t S_EXEC    = 4'd4;
    localparam seq_state_t S_MEMRD   = 4'd5;
    localparam seq_state_t S_MEMWR   = 4'd6;
    localparam seq_state_t S_WRBACK  = 4'd7;
    localparam seq_state_t S_HALTED  = 4'd8;

    seq_state_t  state_q, state_d;
    inst_class_t cls_q, cls_d;
    inst_class_t dec_cls;
    stage_en_t   en_q;
    logic        done_q;
    logic        retire_c;
    logic        illegal_c;
    logic        br_c;
    logic        cyc_inc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    assign dec_cls = inst_class_t'(bus.inst_type);

    // Stage enable pattern for a given state.
    function automatic stage_en_t stage_en(input seq_state_t s);
        stage_en_t e;
        e = '0;
        case (s)
            S_FETCH:   e.fetch  = 1'b1;
            S_DECODE:  e.decode = 1'b1;
            S_OPFETCH: e.reg_r  = 1'b1;
            S_EXEC:    e.alu    = 1'b1;
            S_MEMRD:   e.mem_r  = 1'b1;
            S_MEMWR:   e.mem_w  = 1'b1;
            S_WRBACK:  e.reg_w  = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    // State register; enables/done registered from the next state so they
    // always reflect the current state.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
            cls_q   <= IC_ILLEGAL;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            en_q    <= stage_en(state_d);
            done_q  <= (state_d == S_HALTED);
        end
    end

    // Next-state and input-dependent outputs.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        br_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    IC_ALU, IC_JUMP, IC_STORE, IC_LOAD: state_d = S_OPFETCH;
                    IC_MOVE: state_d = S_WRBACK;
                    IC_JUMPI: begin
                        retire_c = 1'b1;
                        if (bus.is_halt) begin
                            state_d = S_HALTED;
                        end else begin
                            br_c    = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_OPFETCH: begin
                case (cls_q)
                    IC_ALU:   state_d = S_EXEC;
                    IC_STORE: state_d = S_MEMWR;
                    IC_LOAD:  state_d = S_MEMRD;
                    default: begin
                        // Only JUMP/BEQ finishes here.
                        br_c     = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WRBACK;
            end
            S_MEMRD: begin
                if (bus.mem_ready) state_d = S_WRBACK;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_WRBACK: begin
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cyc_inc = (state_q != S_IDLE) && (state_q != S_HALTED);

    perf_counter #(.W(CNT_W), .SATURATE(1'b1)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (init_n),
        .inc   (cyc_inc),
        .count (cycle_cnt)
    );

    perf_counter #(.W(CNT_W), .SATURATE(1'b0)) u_retire_cnt (
        .clk   (clk),
        .rst_n (init_n),
        .inc   (retire_c),
        .count (retire_cnt)
    );

    assign bus.fetch_unit_en = en_q.fetch;
    assign bus.decoder_en    = en_q.decode;
    assign bus.reg_r_en      = en_q.reg_r;
    assign bus.alu_en        = en_q.alu;
    assign bus.reg_w_en      = en_q.reg_w;
    assign bus.memory_r_en   = en_q.mem_r;
    assign bus.memory_w_en   = en_q.mem_w;
    assign bus.br_en         = br_c;
    assign bus.inst_retire   = retire_c;
    assign bus.illegal       = illegal_c;
    assign bus.done          = done_q;
    assign bus.cycle_cnt     = cycle_cnt;
    assign bus.retire_cnt    = retire_cnt;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a CNT_W=16 instance for sequencing and
// a CNT_W=4 instance for counter wrap/saturation.
module tb_exec_sequencer;

    logic clk;
    logic init_n;
    int   tests_run;
    int   tests_failed;

    // Enable vector order: fetch, decode, reg_r, alu, reg_w, mem_r, mem_w, br
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_F    = 8'b1000_0000;
    localparam logic [7:0] E_D    = 8'b0100_0000;
    localparam logic [7:0] E_OF   = 8'b0010_0000;
    localparam logic [7:0] E_EX   = 8'b0001_0000;
    localparam logic [7:0] E_WB   = 8'b0000_1000;
    localparam logic [7:0] E_MR   = 8'b0000_0100;
    localparam logic [7:0] E_MW   = 8'b0000_0010;
    localparam logic [7:0] E_BR   = 8'b0000_0001;

    exec_sequencer_if #(.CNT_W(16)) b16 ();
    exec_sequencer_if #(.CNT_W(4))  b4 ();

    exec_sequencer #(.CNT_W(16)) dut16 (
        .clk    (clk),
        .init_n (init_n),
        .bus    (b16)
    );

    exec_sequencer #(.CNT_W(4)) dut4 (
        .clk    (clk),
        .init_n (init_n),
        .bus    (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] en16();
        return {b16.fetch_unit_en, b16.decoder_en, b16.reg_r_en, b16.alu_en,
                b16.reg_w_en, b16.memory_r_en, b16.memory_w_en, b16.br_en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init_n        = 1'b0;
        b16.start     = 1'b0;
        b16.inst_type = 3'd0;
        b16.is_halt   = 1'b0;
        b16.mem_ready = 1'b0;
        b4.start      = 1'b0;
        b4.inst_type  = 3'd0;
        b4.is_halt    = 1'b0;
        b4.mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        init_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset state
        do_reset();
        #1;
        chk("rst_en", 32'(en16()), 32'(E_NONE));
        chk("rst_flags", {29'd0, b16.inst_retire, b16.illegal, b16.done}, 32'd0);
        chk("rst_cyc", 32'(b16.cycle_cnt), 32'd0);
        chk("rst_ret", 32'(b16.retire_cnt), 32'd0);
        cyc();
        chk("idle_wait_en", 32'(en16()), 32'(E_NONE));
        chk("idle_wait_cyc", 32'(b16.cycle_cnt), 32'd0);

        // ALU: F, D, OF, EX, WB
        b16.inst_type = 3'd1;
        b16.start     = 1'b1;
        cyc();
        b16.start = 1'b0;
        chk("alu_f", 32'(en16()), 32'(E_F));
        cyc();
        chk("alu_d", 32'(en16()), 32'(E_D));
        chk("alu_d_ret", 32'(b16.inst_retire), 32'd0);
        cyc();
        chk("alu_of", 32'(en16()), 32'(E_OF));
        cyc();
        chk("alu_ex", 32'(en16()), 32'(E_EX));
        cyc();
        chk("alu_wb", 32'(en16()), 32'(E_WB));
        chk("alu_wb_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        chk("alu_next_f", 32'(en16()), 32'(E_F));
        chk("alu_ret_cnt", 32'(b16.retire_cnt), 32'd1);
        chk("alu_cyc_cnt", 32'(b16.cycle_cnt), 32'd5);

        // LOAD with three not-ready cycles
        do_reset();
        b16.inst_type = 3'd6;
        b16.start     = 1'b1;
        cyc();
        b16.start = 1'b0;
        cyc();
        cyc();
        chk("ld_of", 32'(en16()), 32'(E_OF));
        cyc();
        chk("ld_mr1", 32'(en16()), 32'(E_MR));
        cyc();
        chk("ld_mr2", 32'(en16()), 32'(E_MR));
        cyc();
        chk("ld_mr3", 32'(en16()), 32'(E_MR));
        chk("ld_mr3_ret", 32'(b16.inst_retire), 32'd0);
        cyc();
        chk("ld_mr4", 32'(en16()), 32'(E_MR));
        b16.mem_ready = 1'b1;
        cyc();
        b16.mem_ready = 1'b0;
        chk("ld_wb", 32'(en16()), 32'(E_WB));
        chk("ld_wb_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        chk("ld_next_f", 32'(en16()), 32'(E_F));
        chk("ld_cyc_cnt", 32'(b16.cycle_cnt), 32'd8);
        chk("ld_ret_cnt", 32'(b16.retire_cnt), 32'd1);

        // HALT: JUMPI class with is_halt
        do_reset();
        b16.inst_type = 3'd2;
        b16.is_halt   = 1'b1;
        b16.start     = 1'b1;
        cyc();
        b16.start = 1'b0;
        cyc();
        chk("hlt_d_en", 32'(en16()), 32'(E_D));
        chk("hlt_d_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        chk("hlt_en", 32'(en16()), 32'(E_NONE));
        chk("hlt_done", 32'(b16.done), 32'd1);
        b16.start = 1'b1;
        cyc();
        cyc();
        b16.start = 1'b0;
        cyc();
        chk("hlt_sticky_en", 32'(en16()), 32'(E_NONE));
        chk("hlt_sticky_done", 32'(b16.done), 32'd1);
        chk("hlt_cyc_cnt", 32'(b16.cycle_cnt), 32'd2);
        chk("hlt_ret_cnt", 32'(b16.retire_cnt), 32'd1);

        // Illegal, then JUMPI and JUMP branch enables
        do_reset();
        b16.inst_type = 3'd7;
        b16.start     = 1'b1;
        cyc();
        b16.start = 1'b0;
        cyc();
        #1;
        chk("ill_d_en", 32'(en16()), 32'(E_D));
        chk("ill_pulse", 32'(b16.illegal), 32'd1);
        chk("ill_ret", 32'(b16.inst_retire), 32'd0);
        cyc();
        chk("ill_back_f", 32'(en16()), 32'(E_F));
        chk("ill_clr", 32'(b16.illegal), 32'd0);
        chk("ill_ret_cnt", 32'(b16.retire_cnt), 32'd0);
        b16.inst_type = 3'd2;
        cyc();
        chk("jmpi_d_br", 32'(en16()), 32'(E_D | E_BR));
        chk("jmpi_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        chk("jmpi_ret_cnt", 32'(b16.retire_cnt), 32'd1);
        b16.inst_type = 3'd3;
        cyc();
        chk("jmp_d", 32'(en16()), 32'(E_D));
        cyc();
        chk("jmp_of_br", 32'(en16()), 32'(E_OF | E_BR));
        chk("jmp_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        chk("jmp_f", 32'(en16()), 32'(E_F));
        chk("jmp_ret_cnt", 32'(b16.retire_cnt), 32'd2);
        chk("jmp_cyc_cnt", 32'(b16.cycle_cnt), 32'd7);

        // STORE completing, then async reset mid-MEMWR
        do_reset();
        b16.inst_type = 3'd5;
        b16.start     = 1'b1;
        cyc();
        b16.start = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("st_mw", 32'(en16()), 32'(E_MW));
        chk("st_mw_wait_ret", 32'(b16.inst_retire), 32'd0);
        b16.mem_ready = 1'b1;
        #1;
        chk("st_mw_ret", 32'(b16.inst_retire), 32'd1);
        cyc();
        b16.mem_ready = 1'b0;
        chk("st_f", 32'(en16()), 32'(E_F));
        chk("st_cyc_cnt", 32'(b16.cycle_cnt), 32'd4);
        cyc();
        cyc();
        cyc();
        chk("st2_mw", 32'(en16()), 32'(E_MW));
        cyc();
        chk("st2_mw_hold", 32'(en16()), 32'(E_MW));
        init_n = 1'b0;
        #1;
        chk("arst_en", 32'(en16()), 32'(E_NONE));
        chk("arst_cyc", 32'(b16.cycle_cnt), 32'd0);
        chk("arst_ret", 32'(b16.retire_cnt), 32'd0);
        @(posedge clk);
        #1;
        init_n = 1'b1;
        cyc();
        chk("arst_idle", 32'(en16()), 32'(E_NONE));

        // Counter boundary on the CNT_W=4 instance: 16 JUMPI instructions
        do_reset();
        b4.inst_type = 3'd2;
        b4.start     = 1'b1;
        cyc();
        b4.start = 1'b0;
        repeat (14) cyc();
        chk("w4_cyc14", 32'(b4.cycle_cnt), 32'd14);
        chk("w4_ret7", 32'(b4.retire_cnt), 32'd7);
        repeat (2) cyc();
        chk("w4_cyc_sat", 32'(b4.cycle_cnt), 32'd15);
        chk("w4_ret8", 32'(b4.retire_cnt), 32'd8);
        repeat (16) cyc();
        chk("w4_ret_wrap", 32'(b4.retire_cnt), 32'd0);
        chk("w4_cyc_hold", 32'(b4.cycle_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
